sbox_share_arb: RTL

- Time-shares one 128-bit SubBytes S-box (existing `sbox` module) between two requesters in the AES encryption core.
  - Round engine: full 128-bit SubBytes.
  - Key expansion: 32-bit SubWord.
- Arbitrates between them, registers the substituted result, and holds it under a valid/ready return handshake until the owning requester accepts it.
- Keeps a single S-box instance in the design instead of a second 32-bit S-box for key expansion.

---
 rtl/sbox_share_arb_pkg.sv | 16 +
 rtl/sbox_share_arb_sbox.sv | 31 +++
 rtl/sbox_share_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/sbox_share_arb_pkg.sv
// Shared AES definitions: requester encoding, hold-state type and datapath widths.
package sbox_share_arb_pkg;

   localparam logic REQ_RND = 1'b0;
   localparam logic REQ_KEY = 1'b1;

   localparam int STATE_W = 128;
   localparam int WORD_W  = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RND_HOLD = 2'd1,
      KEY_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/sbox_share_arb_sbox.sv
// 128-bit AES SubBytes: sixteen independent byte substitutions from the forward table.
module sbox (
   input  logic [127:0] indata,
   output logic [127:0] outdata
);

   // Forward AES S-box, entry 0 leftmost.
   localparam logic [0:255][7:0] SBOX_TBL = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   for (genvar b = 0; b < 16; b++) begin : g_byte
      assign outdata[8*b +: 8] = SBOX_TBL[indata[8*b +: 8]];
   end

endmodule

// File: rtl/sbox_share_arb.sv
// Shares one 128-bit SubBytes S-box between the round engine (full state) and key
// expansion (one SubWord), holding each registered result until its owner takes it.
module sbox_share_arb
   import sbox_share_arb_pkg::*;
#(
   parameter int ARB_MODE = 0   // 0: round-robin on ties, 1: key always wins ties
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               rnd_valid,
   output logic               rnd_ready,
   input  logic [STATE_W-1:0] rnd_data,
   output logic               rnd_rvalid,
   input  logic               rnd_rready,
   output logic [STATE_W-1:0] rnd_result,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic [WORD_W-1:0]  key_data,
   output logic               key_rvalid,
   input  logic               key_rready,
   output logic [WORD_W-1:0]  key_result,
   output logic               busy
);

   state_e               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic [STATE_W-1:0]   rnd_result_q;
   logic [WORD_W-1:0]    key_result_q;
   logic                 free;
   logic                 gnt_rnd, gnt_key;
   logic [STATE_W-1:0]   sbox_in, sbox_out;

   // The S-box may take a new job when nothing is held or the held result drains now.
   always_comb begin
      free = 1'b0;
      case (state_q)
         IDLE:     free = 1'b1;
         RND_HOLD: free = rnd_rready;
         KEY_HOLD: free = key_rready;
         default:  free = 1'b0;
      endcase
      if (flush) free = 1'b0;
   end

   // Pick at most one requester; ties go to key (fixed) or to whoever did not win last.
   always_comb begin
      gnt_rnd = 1'b0;
      gnt_key = 1'b0;
      if (free) begin
         if (rnd_valid && key_valid) begin
            if (ARB_MODE == 1 || last_grant_q == REQ_RND) gnt_key = 1'b1;
            else                                          gnt_rnd = 1'b1;
         end else begin
            gnt_rnd = rnd_valid;
            gnt_key = key_valid;
         end
      end
   end

   // Steer the granted operand into the shared S-box; zero when idle.
   always_comb begin
      sbox_in = '0;
      if (gnt_rnd)      sbox_in = rnd_data;
      else if (gnt_key) sbox_in = {{(STATE_W-WORD_W){1'b0}}, key_data};
   end

   sbox u_sbox (
      .indata  (sbox_in),
      .outdata (sbox_out)
   );

   // Next hold state: flush wins, then a new grant, then a plain drain to IDLE.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      if (flush) begin
         state_d = IDLE;
      end else if (gnt_rnd) begin
         state_d      = RND_HOLD;
         last_grant_d = REQ_RND;
      end else if (gnt_key) begin
         state_d      = KEY_HOLD;
         last_grant_d = REQ_KEY;
      end else if (free) begin
         state_d = IDLE;
      end
   end

   // State, arbitration history and result registers; results update only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_KEY;
         rnd_result_q <= '0;
         key_result_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         if (gnt_rnd) rnd_result_q <= sbox_out;
         if (gnt_key) key_result_q <= sbox_out[WORD_W-1:0];
      end
   end

   assign rnd_ready  = gnt_rnd;
   assign key_ready  = gnt_key;
   assign rnd_rvalid = (state_q == RND_HOLD);
   assign key_rvalid = (state_q == KEY_HOLD);
   assign rnd_result = rnd_result_q;
   assign key_result = key_result_q;
   assign busy       = (state_q != IDLE);

endmodule
